// File: rtl/tt_um_uart_rx.sv
// Oversampling UART receiver (start, DATA_BITS LSB-first, stop) with a valid/ready byte output.
// Byte is valid 1 clk after the stop sample; an unconsumed byte is overwritten and flagged by overrun.
module tt_um_uart_rx #(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic [BW-1:0]          bit_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic [DATA_BITS-1:0]   data_q;
   logic                   valid_q;
   logic                   ferr_q;
   logic                   ovr_q;

   // Synchronizer resets to the idle (high) line level so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
         if (valid_q && data_ready) begin
            valid_q <= 1'b0;
         end
         if (ena) begin
            case (state_q)
               IDLE: begin
                  if (!rx_s) begin
                     state_q <= START;
                     cnt_q   <= '0;
                  end
               end
               START: begin
                  if (cnt_q == CNT_MID) begin
                     cnt_q <= '0;
                     bit_q <= '0;
                     state_q <= rx_s ? IDLE : DATA;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               DATA: begin
                  if (cnt_q == CNT_LAST) begin
                     shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                     cnt_q   <= '0;
                     bit_q   <= bit_q + 1'b1;
                     if (bit_q == BIT_LAST) begin
                        state_q <= STOP;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               STOP: begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_q <= '0;
                     if (rx_s) begin
                        // Delivery wins over a same-edge accept, so valid stays set.
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                        ovr_q   <= valid_q && !data_ready;
                        state_q <= IDLE;
                     end else begin
                        ferr_q  <= 1'b1;
                        state_q <= BREAK;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               BREAK: begin
                  if (rx_s) begin
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_tt_um_uart_rx.sv
// Directed plus randomized frames on two receivers (OVERSAMPLE 4 with ena every clk, OVERSAMPLE 8 with ena every 3rd clk).
module tb_tt_um_uart_rx;

   logic       clk;
   logic       rst_n;
   logic       ena_a, rx_a, rdy_a;
   logic       ena_b, rx_b, rdy_b;
   logic [7:0] dout_a, dout_b;
   logic       vld_a, vld_b, ferr_a, ferr_b, ovr_a, ovr_b;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   int ferr_cnt = 0, ovr_cnt = 0, ferr_b_cnt = 0, ovr_b_cnt = 0;
   int ph = 0;

   // reference model of receiver A: last delivered byte, pending flag, pulse totals
   logic [7:0] m_data;
   logic       m_valid;
   int         m_ferr, m_ovr;

   tt_um_uart_rx dut_a (
      .clk(clk), .rst_n(rst_n), .ena(ena_a), .rx(rx_a),
      .data_out(dout_a), .data_valid(vld_a), .data_ready(rdy_a),
      .frame_err(ferr_a), .overrun(ovr_a)
   );

   tt_um_uart_rx #(.OVERSAMPLE(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .ena(ena_b), .rx(rx_b),
      .data_out(dout_b), .data_valid(vld_b), .data_ready(rdy_b),
      .frame_err(ferr_b), .overrun(ovr_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      ena_b = 1'b0;
      forever begin
         @(negedge clk);
         ph = (ph + 1) % 3;
         ena_b = (ph == 0);
      end
   end

   always @(negedge clk) begin
      if (ferr_a === 1'b1) ferr_cnt++;
      if (ovr_a === 1'b1) ovr_cnt++;
      if (ferr_b === 1'b1) ferr_b_cnt++;
      if (ovr_b === 1'b1) ovr_b_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [7:0] b, input logic stop);
      rx_a = 1'b0;
      clks(4);
      for (int i = 0; i < 8; i++) begin
         rx_a = b[i];
         clks(4);
      end
      rx_a = stop;
      clks(4);
   endtask

   task automatic send_b(input logic [7:0] b);
      rx_b = 1'b0;
      clks(24);
      for (int i = 0; i < 8; i++) begin
         rx_b = b[i];
         clks(24);
      end
      rx_b = 1'b1;
      clks(24);
   endtask

   task automatic model_frame(input logic [7:0] b, input logic stop);
      if (stop) begin
         if (m_valid) m_ovr++;
         m_data  = b;
         m_valid = 1'b1;
      end else begin
         m_ferr++;
      end
   endtask

   task automatic accept_a();
      clks(1);
      rdy_a = 1'b1;
      clks(1);
      rdy_a = 1'b0;
      m_valid = 1'b0;
   endtask

   task automatic check_model(input string tag);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk({tag, "_vld"}, vld_a, m_valid);
      chk({tag, "_dat"}, dout_a, m_data);
      chk({tag, "_ferr"}, ferr_cnt, m_ferr);
      chk({tag, "_ovr"}, ovr_cnt, m_ovr);
      clks(1);
   endtask

   initial begin
      int         lat;
      logic       stay;
      logic [7:0] rb;
      logic       rs;

      rx_a = 1'b1; rx_b = 1'b1; ena_a = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
      m_data = 8'h00; m_valid = 1'b0; m_ferr = 0; m_ovr = 0;
      rst_n = 1'b0;
      clks(3);
      chk("rst_dat", dout_a, 8'h00);
      chk("rst_vld", vld_a, 1'b0);
      chk("rst_ferr", ferr_a, 1'b0);
      chk("rst_ovr", ovr_a, 1'b0);
      chk("rst_vld_b", vld_b, 1'b0);
      rst_n = 1'b1;
      clks(4);

      // basic byte, exact latency, hold while not accepted, then accept
      send_a(8'hA5, 1'b1);
      model_frame(8'hA5, 1'b1);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!vld_a && lat < 20);
      chk("a5_latency", lat, 2);
      chk("a5_dat", dout_a, 8'hA5);
      stay = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (vld_a !== 1'b1 || dout_a !== 8'hA5) stay = 1'b0;
      end
      chk("a5_hold20", stay, 1'b1);
      accept_a();
      @(negedge clk);
      chk("a5_accepted", vld_a, 1'b0);

      // one-tick glitch is rejected
      clks(1);
      rx_a = 1'b0;
      clks(1);
      rx_a = 1'b1;
      clks(16);
      check_model("glitch");
      send_a(8'h3C, 1'b1);
      model_frame(8'h3C, 1'b1);
      check_model("after_glitch");
      accept_a();

      // bad stop bit followed by a held-low line
      send_a(8'h3C, 1'b0);
      model_frame(8'h3C, 1'b0);
      clks(48);
      check_model("break");
      rx_a = 1'b1;
      clks(8);
      send_a(8'h81, 1'b1);
      model_frame(8'h81, 1'b1);
      check_model("after_break");
      accept_a();

      // back to back with no consumer: overrun
      send_a(8'h11, 1'b1);
      model_frame(8'h11, 1'b1);
      send_a(8'h22, 1'b1);
      model_frame(8'h22, 1'b1);
      check_model("b2b_ovr");
      accept_a();

      // back to back, accept on the delivery edge of the second byte
      send_a(8'h33, 1'b1);
      model_frame(8'h33, 1'b1);
      send_a(8'h44, 1'b1);
      rdy_a = 1'b1;
      clks(1);
      rdy_a = 1'b0;
      m_valid = 1'b0;
      model_frame(8'h44, 1'b1);
      check_model("simul_accept");
      accept_a();

      // reset in the middle of data bit 4 of 0xFF
      rx_a = 1'b0;
      clks(4);
      rx_a = 1'b1;
      clks(18);
      rst_n = 1'b0;
      #1;
      chk("midrst_dat", dout_a, 8'h00);
      chk("midrst_vld", vld_a, 1'b0);
      chk("midrst_ferr", ferr_a, 1'b0);
      chk("midrst_ovr", ovr_a, 1'b0);
      m_data = 8'h00;
      m_valid = 1'b0;
      clks(3);
      rst_n = 1'b1;
      clks(40);
      check_model("post_rst");
      send_a(8'h5A, 1'b1);
      model_frame(8'h5A, 1'b1);
      check_model("post_rst_5a");

      // randomized frames against the model
      for (int k = 0; k < 8; k++) begin
         rb = 8'($urandom);
         rs = ($urandom_range(0, 3) != 0);
         send_a(rb, rs);
         model_frame(rb, rs);
         if (!rs) begin
            clks($urandom_range(4, 40));
            rx_a = 1'b1;
         end
         clks(8);
         check_model("rand");
         if ($urandom_range(0, 1) == 1) accept_a();
      end

      // OVERSAMPLE=8 receiver with ena every 3rd clk
      send_b(8'h5A);
      lat = 0;
      while (!vld_b && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("b_vld", vld_b, 1'b1);
      chk("b_dat", dout_b, 8'h5A);
      do begin
         @(negedge clk);
         #1;
      end while (ena_b);
      rdy_b = 1'b1;
      @(posedge clk);
      #1;
      rdy_b = 1'b0;
      @(negedge clk);
      chk("b_accept_no_ena", vld_b, 1'b0);
      chk("b_dat_kept", dout_b, 8'h5A);
      chk("b_ferr", ferr_b_cnt, 0);
      chk("b_ovr", ovr_b_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
